data_mem_unit: RTL

Parametrised byte-addressable data memory for the MIPS datapath, replacing the fixed 1024-word, word-only memory. It sits on the MEM stage. It accepts byte, halfword and word loads and stores, with optional sign extension and big-endian lane mapping. It inserts a configurable number of wait states behind a req/ready handshake and flags misaligned or illegal accesses instead of performing them.

---
 rtl/data_mem_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/data_mem_unit.sv
// Byte-addressable big-endian data memory for the MEM stage: byte/half/word
// loads and stores behind a req/ready handshake with programmable wait states.
module data_mem_unit #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              rd_wr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] endereco,
  input  logic [31:0]       entrada,
  output logic [31:0]       saida,
  output logic              ready,
  output logic              erro,
  output logic              busy
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("data_mem_unit: WAIT_STATES must be in 0..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] saida_q, saida_d;
  logic        erro_q, erro_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        accept, access, mem_we;

  logic              rd_wr_q, sext_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0] mem [DEPTH] = '{0: 32'd2001, 1: 32'd4001, 2: 32'd5001, 3: 32'd3001, default: 32'd0};

  logic [31:0] word_rd, wr_word, ld_val, result;
  logic [1:0]  lane;
  logic        hlane, legal;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Lane selection: byte offset 0 is the most significant byte of the word.
  always_comb begin
    word_rd = mem[addr_q[ADDR_W-1:2]];
    lane    = 2'd3 - addr_q[1:0];
    hlane   = ~addr_q[1];
    legal   = (size_q == 2'b00) ||
              (size_q == 2'b01 && !addr_q[0]) ||
              (size_q == 2'b10 && addr_q[1:0] == 2'b00);
    wr_word = word_rd;
    case (size_q)
      2'b00:   wr_word[{lane, 3'b000} +: 8]   = wdata_q[7:0];
      2'b01:   wr_word[{hlane, 4'b0000} +: 16] = wdata_q[15:0];
      default: wr_word = wdata_q;
    endcase
    rd_byte = word_rd[{lane, 3'b000} +: 8];
    rd_half = word_rd[{hlane, 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_val = {{24{sext_q & rd_byte[7]}}, rd_byte};
      2'b01:   ld_val = {{16{sext_q & rd_half[15]}}, rd_half};
      default: ld_val = word_rd;
    endcase
    result = rd_wr_q ? wr_word : ld_val;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    saida_d = saida_q;
    erro_d  = erro_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          saida_d = legal ? result : 32'd0;
          erro_d  = ~legal;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_RESP);
    busy_d  = (state_d != S_IDLE);
    mem_we  = access & legal & rd_wr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      saida_q <= 32'd0;
      erro_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      saida_q <= saida_d;
      erro_q  <= erro_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Request fields and storage carry no reset; writes are gated by FSM state.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_wr_q <= rd_wr;
      size_q  <= size;
      sext_q  <= sign_ext;
      addr_q  <= endereco;
      wdata_q <= entrada;
    end
    if (mem_we) begin
      mem[addr_q[ADDR_W-1:2]] <= wr_word;
    end
  end

  assign saida = saida_q;
  assign erro  = erro_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule
